// File: rtl/snake_pkg.sv
// Shared widths, default colours and rebuild FSM state encoding for the snake tile renderer.
package snake_pkg;

  localparam int unsigned COLOR_W = 12;
  localparam int unsigned COORD_W = 32;

  localparam logic [COLOR_W-1:0] DEF_BODY_COLOR = 12'h0F0;
  localparam logic [COLOR_W-1:0] DEF_HEAD_COLOR = 12'h0A0;
  localparam logic [COLOR_W-1:0] GAMEOVER_COLOR = 12'hF00;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CLEAR = 2'd1;
  localparam state_t FILL  = 2'd2;

  // Row-major tile number; callers truncate to the tile index width after bounds checks.
  function automatic logic [COORD_W-1:0] tile_number(input logic [COORD_W-1:0] col,
                                                     input logic [COORD_W-1:0] row,
                                                     input int unsigned       grid_w);
    return row * COORD_W'(grid_w) + col;
  endfunction

endpackage

// File: rtl/snake_tile_renderer_if.sv
// Pixel, segment-list and status signals between the VGA pipeline and the snake tile renderer.
interface snake_tile_renderer_if #(
  parameter int unsigned MAX_SEGS = 100
);
  import snake_pkg::*;

  logic                        screen_end;
  logic                        active;
  logic [9:0]                  x;
  logic [8:0]                  y;
  logic [COORD_W*MAX_SEGS-1:0] seg_x;
  logic [COORD_W*MAX_SEGS-1:0] seg_y;
  logic [7:0]                  seg_len;
  logic                        game_done;
  logic [COLOR_W-1:0]          bg_color;
  logic [COLOR_W-1:0]          rgb_out;
  logic                        busy;
  logic                        oob_err;

  modport master (
    output screen_end, active, x, y, seg_x, seg_y, seg_len, game_done, bg_color,
    input  rgb_out, busy, oob_err
  );

  modport slave (
    input  screen_end, active, x, y, seg_x, seg_y, seg_len, game_done, bg_color,
    output rgb_out, busy, oob_err
  );

endinterface

// File: rtl/snake_tile_renderer_tile_locator.sv
// Combinational pixel -> board tile mapping: reports whether x/y hits the filled box of a tile.
module tile_locator #(
  parameter int unsigned X0        = 48,
  parameter int unsigned Y0        = 48,
  parameter int unsigned TILE_SIZE = 48,
  parameter int unsigned BOX_SIZE  = 40,
  parameter int unsigned GRID_W    = 8,
  parameter int unsigned GRID_H    = 8,
  parameter int unsigned TILE_W    = $clog2(GRID_W * GRID_H)
) (
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic              in_box,
  output logic [TILE_W-1:0] tile_idx
);

  logic [9:0] dx, col, off_x;
  logic [8:0] dy, row, off_y;
  logic       in_board;

  always_comb begin
    dx       = x - 10'(X0);
    dy       = y - 9'(Y0);
    col      = dx / 10'(TILE_SIZE);
    off_x    = dx % 10'(TILE_SIZE);
    row      = dy / 9'(TILE_SIZE);
    off_y    = dy % 9'(TILE_SIZE);
    // x/y below the origin wrap to large dx/dy, so the explicit >= checks are still needed
    in_board = (x >= 10'(X0)) && (y >= 9'(Y0)) &&
               (col < 10'(GRID_W)) && (row < 9'(GRID_H));
    in_box   = in_board && (off_x < 10'(BOX_SIZE)) && (off_y < 9'(BOX_SIZE));
    tile_idx = TILE_W'(row) * TILE_W'(GRID_W) + TILE_W'(col);
  end

endmodule

// File: rtl/snake_tile_renderer.sv
// Snake board pixel colour generator: per-frame segment snapshot, occupancy bitmap rebuild FSM and
// registered colour output. Define SNAKE_RENDER_GAMEOVER_EN for the red game-over palette.
module snake_tile_renderer
  import snake_pkg::*;
#(
  parameter int unsigned        GRID_W     = 8,
  parameter int unsigned        GRID_H     = 8,
  parameter int unsigned        MAX_SEGS   = 100,
  parameter int unsigned        X0         = 48,
  parameter int unsigned        Y0         = 48,
  parameter int unsigned        TILE_SIZE  = 48,
  parameter int unsigned        BOX_SIZE   = 40,
  parameter logic [COLOR_W-1:0] BODY_COLOR = DEF_BODY_COLOR,
  parameter logic [COLOR_W-1:0] HEAD_COLOR = DEF_HEAD_COLOR
) (
  input logic                   clk,
  input logic                   reset,
  snake_tile_renderer_if.slave  bus
);

  localparam int unsigned CELLS  = GRID_W * GRID_H;
  localparam int unsigned TILE_W = $clog2(CELLS);
  localparam int unsigned SLOT_W = COORD_W * MAX_SEGS;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   seg_x_q, seg_y_q;
  logic [7:0]          len_q, idx_q, len_clamped;
  logic [CELLS-1:0]    bitmap_q;
  logic [TILE_W-1:0]   head_tile_q;
  logic                head_valid_q;
  logic                oob_q;
  logic [COLOR_W-1:0]  rgb_q, rgb_d;

  logic [COORD_W-1:0]  cur_x, cur_y, head_x, head_y;
  logic                cur_in, head_in;
  logic [TILE_W-1:0]   cur_tile, head_tile;

  logic                in_box;
  logic [TILE_W-1:0]   tile_idx;

  assign len_clamped = (bus.seg_len > 8'(MAX_SEGS)) ? 8'(MAX_SEGS) : bus.seg_len;

  assign cur_x     = seg_x_q[idx_q * COORD_W +: COORD_W];
  assign cur_y     = seg_y_q[idx_q * COORD_W +: COORD_W];
  assign cur_in    = (cur_x < COORD_W'(GRID_W)) && (cur_y < COORD_W'(GRID_H));
  assign cur_tile  = TILE_W'(tile_number(cur_x, cur_y, GRID_W));

  assign head_x    = seg_x_q[COORD_W-1:0];
  assign head_y    = seg_y_q[COORD_W-1:0];
  assign head_in   = (head_x < COORD_W'(GRID_W)) && (head_y < COORD_W'(GRID_H));
  assign head_tile = TILE_W'(tile_number(head_x, head_y, GRID_W));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.screen_end) state_d = CLEAR;
      CLEAR:   state_d = (len_q == 8'd0) ? IDLE : FILL;
      FILL:    if (idx_q == len_q - 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Segment snapshot needs no reset: it is only read after a screen_end has loaded it.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.screen_end) begin
      seg_x_q <= bus.seg_x;
      seg_y_q <= bus.seg_y;
    end
  end

`ifdef SNAKE_RENDER_GAMEOVER_EN
  logic game_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      game_done_q <= 1'b0;
    end else if (state_q == IDLE && bus.screen_end) begin
      game_done_q <= bus.game_done;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      bitmap_q     <= '0;
      head_tile_q  <= '0;
      head_valid_q <= 1'b0;
      oob_q        <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      case (state_q)
        IDLE: begin
          if (bus.screen_end) len_q <= len_clamped;
        end
        CLEAR: begin
          bitmap_q     <= '0;
          idx_q        <= '0;
          head_tile_q  <= head_tile;
          head_valid_q <= (len_q != 8'd0) && head_in;
        end
        FILL: begin
          if (cur_in) bitmap_q[cur_tile] <= 1'b1;
          else        oob_q              <= 1'b1;
          idx_q <= idx_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  tile_locator #(
    .X0        (X0),
    .Y0        (Y0),
    .TILE_SIZE (TILE_SIZE),
    .BOX_SIZE  (BOX_SIZE),
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H)
  ) u_tile_locator (
    .x        (bus.x),
    .y        (bus.y),
    .in_box   (in_box),
    .tile_idx (tile_idx)
  );

  logic [COLOR_W-1:0] head_c, body_c, bg_c;

`ifdef SNAKE_RENDER_GAMEOVER_EN
  assign head_c = game_done_q ? GAMEOVER_COLOR : HEAD_COLOR;
  assign body_c = game_done_q ? GAMEOVER_COLOR : BODY_COLOR;
  assign bg_c   = game_done_q ? {1'b1, bus.bg_color[COLOR_W-2:0]} : bus.bg_color;
`else
  logic unused_game_done;
  assign unused_game_done = bus.game_done;
  assign head_c = HEAD_COLOR;
  assign body_c = BODY_COLOR;
  assign bg_c   = bus.bg_color;
`endif

  // A bitmap still being rebuilt is shown as-is; it settles well before the next visible line.
  always_comb begin
    rgb_d = bg_c;
    if (!bus.active)                                             rgb_d = '0;
    else if (in_box && head_valid_q && tile_idx == head_tile_q)  rgb_d = head_c;
    else if (in_box && bitmap_q[tile_idx])                       rgb_d = body_c;
  end

  // The snapshot clock (screen_end seen in IDLE) counts as part of the rebuild.
  assign bus.busy    = (state_q != IDLE) || bus.screen_end;
  assign bus.rgb_out = rgb_q;
  assign bus.oob_err = oob_q;

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Scoreboard bench for snake_tile_renderer: per-scenario tasks, expected pixels queued at drive time.
module tb_snake_tile_renderer;

  localparam logic [11:0] HEAD = 12'h0A0;
  localparam logic [11:0] BODY = 12'h0F0;
  localparam logic [11:0] GO   = 12'hF00;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [11:0] exp_q[$];
  string       nm_q[$];

  snake_tile_renderer_if #(.MAX_SEGS(100)) bus ();

  snake_tile_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic set_seg(input int i, input logic [31:0] sx, input logic [31:0] sy);
    bus.seg_x[i*32 +: 32] = sx;
    bus.seg_y[i*32 +: 32] = sy;
  endtask

  // Drive one pixel; compare the pixel driven one clock earlier against its queued expectation.
  task automatic pix(input int px, input int py, input bit act, input logic [11:0] bg,
                     input logic [11:0] exp, input string nm);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      string       n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (bus.rgb_out !== e) begin
        failures++;
        $display("FAIL %s rgb_out=%h expected=%h", n, bus.rgb_out, e);
      end
    end
    bus.x        = 10'(px);
    bus.y        = 9'(py);
    bus.active   = act;
    bus.bg_color = bg;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
  endtask

  task automatic drain();
    @(negedge clk);
    if (exp_q.size() != 0) begin
      logic [11:0] e;
      string       n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (bus.rgb_out !== e) begin
        failures++;
        $display("FAIL %s rgb_out=%h expected=%h", n, bus.rgb_out, e);
      end
    end
    bus.active = 1'b0;
  endtask

  // Pulse screen_end and count clocks with busy high; optionally re-pulse screen_end mid-rebuild.
  task automatic run_frame(input int exp_busy, input int repulse_at, input string nm);
    int cnt;
    @(negedge clk);
    bus.screen_end = 1'b1;
    #1;
    cnt = bus.busy ? 1 : 0;
    @(negedge clk);
    bus.screen_end = 1'b0;
    #1;
    while (bus.busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
      bus.screen_end = (cnt == repulse_at);
      if (cnt == repulse_at) set_seg(2, 32'd6, 32'd6);
      #1;
    end
    bus.screen_end = 1'b0;
    checks++;
    if (cnt != exp_busy) begin
      failures++;
      $display("FAIL %s busy_clks=%0d expected=%0d", nm, cnt, exp_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.active   = 1'b1;
    bus.bg_color = 12'h555;
    repeat (2) @(negedge clk);
    checks += 3;
    if (bus.rgb_out !== 12'h000) begin
      failures++; $display("FAIL reset_rgb rgb_out=%h expected=000", bus.rgb_out);
    end
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy busy=%b expected=0", bus.busy);
    end
    if (bus.oob_err !== 1'b0) begin
      failures++; $display("FAIL reset_oob oob_err=%b expected=0", bus.oob_err);
    end
    reset = 1'b1;
    pix(48, 48, 1'b1, 12'h123, 12'h123, "idle_bg_tile00");
    pix(200, 300, 1'b1, 12'h456, 12'h456, "idle_bg_mid");
    pix(5, 5, 1'b1, 12'h789, 12'h789, "idle_bg_border");
    pix(48, 48, 1'b0, 12'h789, 12'h000, "idle_inactive");
    drain();
  endtask

  task automatic test_head_only();
    set_seg(0, 32'd0, 32'd0);
    bus.seg_len = 8'd1;
    run_frame(3, -1, "head_busy");
    pix(48, 48, 1'b1, 12'h321, HEAD, "head_pixel");
    pix(87, 87, 1'b1, 12'h321, HEAD, "head_box_edge");
    pix(88, 48, 1'b1, 12'h321, 12'h321, "head_gap");
    pix(96, 48, 1'b1, 12'h321, 12'h321, "head_next_tile");
    drain();
  endtask

  task automatic test_three_segs();
    set_seg(0, 32'd2, 32'd1);
    set_seg(1, 32'd3, 32'd1);
    set_seg(2, 32'd3, 32'd2);
    bus.seg_len = 8'd3;
    run_frame(5, -1, "three_busy");
    pix(144, 96, 1'b1, 12'h00F, HEAD, "three_head");
    pix(192, 96, 1'b1, 12'h00F, BODY, "three_body1");
    pix(192, 144, 1'b1, 12'h00F, BODY, "three_body2");
    pix(240, 96, 1'b1, 12'h00F, 12'h00F, "three_bg");
    pix(48, 48, 1'b1, 12'h00F, 12'h00F, "three_old_head_gone");
    drain();
    checks++;
    if (bus.oob_err !== 1'b0) begin
      failures++; $display("FAIL three_oob oob_err=%b expected=0", bus.oob_err);
    end
  endtask

  task automatic test_oob();
    set_seg(0, 32'd5, 32'd5);
    set_seg(1, 32'd8, 32'd0);
    set_seg(2, 32'h0100_0002, 32'd0);
    bus.seg_len = 8'd3;
    run_frame(5, -1, "oob_busy");
    checks++;
    if (bus.oob_err !== 1'b1) begin
      failures++; $display("FAIL oob_set oob_err=%b expected=1", bus.oob_err);
    end
    pix(288, 288, 1'b1, 12'h0C0, HEAD, "oob_head");
    pix(48, 96, 1'b1, 12'h0C0, 12'h0C0, "oob_no_wrap_row");
    pix(144, 48, 1'b1, 12'h0C0, 12'h0C0, "oob_no_truncate");
    drain();
    set_seg(0, 32'd0, 32'd0);
    bus.seg_len = 8'd1;
    run_frame(3, -1, "oob_valid_busy");
    checks++;
    if (bus.oob_err !== 1'b1) begin
      failures++; $display("FAIL oob_sticky oob_err=%b expected=1", bus.oob_err);
    end
    pix(48, 48, 1'b1, 12'h0C0, HEAD, "oob_valid_head");
    pix(288, 288, 1'b1, 12'h0C0, 12'h0C0, "oob_valid_old_gone");
    drain();
  endtask

  task automatic test_busy_ignore();
    set_seg(0, 32'd1, 32'd1);
    set_seg(1, 32'd2, 32'd1);
    set_seg(2, 32'd3, 32'd1);
    bus.seg_len = 8'd3;
    // Slot 2 moves to (6,6) and screen_end re-pulses during FILL; neither may take effect.
    run_frame(5, 2, "ignore_busy");
    pix(96, 96, 1'b1, 12'hABC, HEAD, "ignore_head");
    pix(144, 96, 1'b1, 12'hABC, BODY, "ignore_body");
    pix(192, 96, 1'b1, 12'hABC, BODY, "ignore_snapshot_slot2");
    pix(336, 336, 1'b1, 12'hABC, 12'hABC, "ignore_new_slot2");
    drain();
  endtask

  task automatic test_clamp_gameover();
    logic [11:0] h, b, g;
    for (int i = 0; i < 100; i++) set_seg(i, 32'(i % 8), 32'((i / 8) % 8));
    bus.seg_len   = 8'd200;
    bus.game_done = 1'b1;
    bus.active    = 1'b0;
    run_frame(102, -1, "clamp_busy");
    bus.game_done = 1'b0;
`ifdef SNAKE_RENDER_GAMEOVER_EN
    h = GO; b = GO; g = 12'h923;
`else
    h = HEAD; b = BODY; g = 12'h123;
`endif
    pix(48, 48, 1'b0, 12'h123, 12'h000, "clamp_inactive_head");
    pix(96, 48, 1'b0, 12'h123, 12'h000, "clamp_inactive_body");
    pix(48, 48, 1'b1, 12'h123, h, "go_head");
    pix(96, 48, 1'b1, 12'h123, b, "go_body");
    pix(384, 384, 1'b1, 12'h123, b, "go_body_corner");
    pix(88, 48, 1'b1, 12'h123, g, "go_bg");
    drain();
  endtask

  initial begin
    bus.screen_end = 1'b0;
    bus.active     = 1'b0;
    bus.x          = '0;
    bus.y          = '0;
    bus.seg_x      = '0;
    bus.seg_y      = '0;
    bus.seg_len    = '0;
    bus.game_done  = 1'b0;
    bus.bg_color   = '0;
    reset          = 1'b0;
    test_reset();
    test_head_only();
    test_three_segs();
    test_oob();
    test_busy_ignore();
    test_clamp_gameover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
